// File: rtl/bcd_calc_pkg.sv
// Shared types and helpers for the digit-serial BCD calculator.
// Op/state enums, digit width and the 9's-complement helper.
package bcd_calc_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    function automatic logic [DIGIT_W-1:0] bcd_nines(
        input logic [DIGIT_W-1:0] d
    );
        return 4'd9 - d;
    endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// One-digit BCD adder with decimal (+6) correction.
// Shared by the magnitude pass and the 10's-complement pass.
module bcd_digit_slice
    import bcd_calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] adj;

    assign raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    assign adj  = raw + 5'd6;
    assign cout = raw > 5'd9;
    assign s    = cout ? adj[DIGIT_W-1:0] : raw[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_calc_serial.sv
// Sign-magnitude BCD accumulator, one digit per clock through a
// single shared digit slice.
module bcd_calc_serial
    import bcd_calc_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic                      clr,
    input  logic [3:0]                digit_in,
    input  logic                      digit_we,
    input  logic                      op_we,
    input  logic                      op_sub,
    input  logic                      eq,
    output logic [DIGIT_W*DIGITS-1:0] display,
    output logic                      neg,
    output logic                      ovf,
    output logic                      busy,
    output logic                      err
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [W-1:0]  entry;
    logic [W-1:0]  acc_mag;
    logic          acc_neg;
    op_t           pending;
    logic          show_acc;
    logic          ovf_q;
    logic          err_q;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  r_sh;
    logic          sub_eff;
    logic          carry;
    logic [IW-1:0] idx;

    state_t        state;
    state_t        state_nx;

    logic          idle;
    logic          do_eval;
    logic          do_dig;
    logic          start;
    logic          last;
    logic          mag_zero;
    logic          sub_now;

    logic [DIGIT_W-1:0] sl_a;
    logic [DIGIT_W-1:0] sl_b;
    logic [DIGIT_W-1:0] sl_s;
    logic               sl_cout;
    logic [W-1:0]       r_next;

    assign idle     = state == S_IDLE;
    assign do_eval  = idle & (eq | op_we);
    assign do_dig   = idle & digit_we & ~eq & ~op_we;
    assign start    = do_eval & (pending != OP_NONE);
    assign last     = idx == LAST;
    assign sub_now  = (pending == OP_SUB) ^ acc_neg;
    assign r_next   = {sl_s, r_sh[W-1:DIGIT_W]};
    assign mag_zero = r_next == '0;

    // FIX complements the stored result; CALC adds the latched operands
    always_comb begin
        sl_a = a_sh[DIGIT_W-1:0];
        sl_b = sub_eff ? bcd_nines(b_sh[DIGIT_W-1:0])
                       : b_sh[DIGIT_W-1:0];
        if (state == S_FIX) begin
            sl_a = bcd_nines(r_sh[DIGIT_W-1:0]);
            sl_b = '0;
        end
    end

    bcd_digit_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N || clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_CALC;
            S_CALC: if (last) begin
                state_nx = (sub_eff & ~sl_cout) ? S_FIX : S_IDLE;
            end
            S_FIX:  if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N || clr) begin
            entry    <= '0;
            acc_mag  <= '0;
            acc_neg  <= 1'b0;
            pending  <= OP_NONE;
            show_acc <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            sub_eff  <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
        end else begin
            err_q <= do_dig & (digit_in > 4'd9);
            if (do_dig && digit_in <= 4'd9) begin
                entry    <= {entry[W-DIGIT_W-1:0], digit_in};
                show_acc <= 1'b0;
            end
            if (do_eval) begin
                if (pending == OP_NONE) begin
                    acc_mag <= entry;
                    acc_neg <= 1'b0;
                end else begin
                    a_sh    <= acc_mag;
                    b_sh    <= entry;
                    r_sh    <= '0;
                    sub_eff <= sub_now;
                    carry   <= sub_now;
                    idx     <= '0;
                end
                if (eq) begin
                    pending  <= OP_NONE;
                    show_acc <= 1'b1;
                end else begin
                    pending <= op_sub ? OP_SUB : OP_ADD;
                end
                entry <= '0;
            end
            if (state == S_CALC) begin
                a_sh  <= a_sh >> DIGIT_W;
                b_sh  <= b_sh >> DIGIT_W;
                r_sh  <= r_next;
                carry <= sl_cout;
                idx   <= idx + 1'b1;
                if (last) begin
                    if (sub_eff && !sl_cout) begin
                        carry <= 1'b1;
                        idx   <= '0;
                    end else begin
                        acc_mag <= r_next;
                        acc_neg <= acc_neg & ~mag_zero;
                        if (!sub_eff && sl_cout) ovf_q <= 1'b1;
                    end
                end
            end
            if (state == S_FIX) begin
                r_sh  <= r_next;
                carry <= sl_cout;
                idx   <= idx + 1'b1;
                if (last) begin
                    acc_mag <= r_next;
                    acc_neg <= ~acc_neg & ~mag_zero;
                end
            end
        end
    end

    assign display = show_acc ? acc_mag : entry;
    assign neg     = show_acc & acc_neg;
    assign ovf     = ovf_q;
    assign busy    = ~idle;
    assign err     = err_q;

endmodule
